// File: rtl/riscv_defines.sv
// Shared types and helpers for the push/pop micro-op sequencer.
// Holds the op/state enums, the minimum legal rlist and the slot-to-GPR map.
package riscv_defines;

  typedef enum logic [1:0] {
    PP_PUSH    = 2'd0,
    PP_POP     = 2'd1,
    PP_POPRET  = 2'd2,
    PP_POPRETZ = 2'd3
  } pushpop_op_e;

  typedef enum logic [2:0] {
    PP_IDLE  = 3'd0,
    PP_MEM   = 3'd1,
    PP_SPADJ = 3'd2,
    PP_ZERO  = 3'd3,
    PP_RET   = 3'd4
  } pp_state_e;

  localparam logic [3:0] PP_RLIST_MIN = 4'd4;
  localparam logic [4:0] PP_REG_SP    = 5'd2;
  localparam logic [4:0] PP_REG_A0    = 5'd10;

  // Slot k of the register list: x1, x8, x9, then x18..x27.
  function automatic logic [4:0] pp_reg_of(input logic [3:0] k);
    logic [4:0] r;
    case (k)
      4'd0:    r = 5'd1;
      4'd1:    r = 5'd8;
      4'd2:    r = 5'd9;
      default: r = 5'(k) + 5'd15;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riscv_pushpop_frame_calc.sv
// Combinational frame sizing: register count, aligned frame size and the
// signed sp adjustment for one push/pop encoding.
module riscv_pushpop_frame_calc
  import riscv_defines::*;
#(
  parameter int XLEN        = 32,
  parameter int STACK_ALIGN = 16,
  parameter int SPIMM_W     = 5
) (
  input  logic [3:0]         rlist,
  input  logic [SPIMM_W-1:0] spimm,
  input  logic [1:0]         op,
  output logic [3:0]         n_regs,
  output logic [XLEN-1:0]    total,
  output logic [XLEN-1:0]    sp_adj,
  output logic               illegal
);

  localparam logic [XLEN-1:0] SLOT     = XLEN'(XLEN / 8);
  localparam logic [XLEN-1:0] ALIGN    = XLEN'(STACK_ALIGN);
  localparam logic [XLEN-1:0] ALIGN_M1 = XLEN'(STACK_ALIGN - 1);

  logic [XLEN-1:0] raw_bytes;
  logic [XLEN-1:0] base;

  always_comb begin
    illegal   = (rlist < PP_RLIST_MIN);
    // rlist 15 covers s10 and s11 together, so it saturates at 13 registers.
    n_regs    = (rlist == 4'd15) ? 4'd13 : (rlist - 4'd3);
    raw_bytes = XLEN'(n_regs) * SLOT;
    base      = (raw_bytes + ALIGN_M1) & ~ALIGN_M1;
    total     = base + XLEN'(spimm) * ALIGN;
    sp_adj    = (op == PP_PUSH) ? -total : total;
  end

endmodule

// File: rtl/riscv_pushpop_sequencer.sv
// Zcmp push/pop expander: walks the register list through LSU requests, then
// adjusts sp, optionally clears a0 and optionally returns through ra.
module riscv_pushpop_sequencer
  import riscv_defines::*;
#(
  parameter int XLEN        = 32,
  parameter int STACK_ALIGN = 16,
  parameter int SPIMM_W     = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [3:0]         rlist_i,
  input  logic [SPIMM_W-1:0] spimm_i,
  input  logic               stall_i,
  input  logic               kill_i,
  input  logic               mem_gnt_i,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [4:0]         mem_reg_o,
  output logic [XLEN-1:0]    mem_off_o,
  output logic               alu_we_o,
  output logic [4:0]         alu_rd_o,
  output logic [XLEN-1:0]    alu_imm_o,
  output logic               ret_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               illegal_o,
  output logic [2:0]         dbg_state_o
);

  localparam logic [XLEN-1:0] SLOT = XLEN'(XLEN / 8);

  // Handshake: a memory step retires only when mem_req_o & mem_gnt_i are both
  // high with no stall and no kill; mem_req_o and its payload never depend on
  // mem_gnt_i and hold steady until that retirement.
  pp_state_e       state_q, state_d;
  logic [3:0]      j_q, n_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] total_q, sp_adj_q;
  logic            illegal_q;

  logic [3:0]      fc_n;
  logic [XLEN-1:0] fc_total, fc_sp_adj;
  logic            fc_illegal;
  logic            accept, step_ok;
  logic [XLEN-1:0] j_bytes;

  riscv_pushpop_frame_calc #(
    .XLEN(XLEN), .STACK_ALIGN(STACK_ALIGN), .SPIMM_W(SPIMM_W)
  ) u_frame_calc (
    .rlist   (rlist_i),
    .spimm   (spimm_i),
    .op      (op_i),
    .n_regs  (fc_n),
    .total   (fc_total),
    .sp_adj  (fc_sp_adj),
    .illegal (fc_illegal)
  );

  assign accept      = (state_q == PP_IDLE) && start_i && !stall_i;
  assign step_ok     = mem_gnt_i && !stall_i && !kill_i;
  assign j_bytes     = XLEN'(j_q) * SLOT;
  assign busy_o      = (state_q != PP_IDLE) || (accept && !fc_illegal);
  assign illegal_o   = illegal_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PP_IDLE;
      j_q       <= '0;
      n_q       <= '0;
      op_q      <= '0;
      total_q   <= '0;
      sp_adj_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= accept && fc_illegal;
      if (accept && !fc_illegal) begin
        j_q      <= 4'd1;
        n_q      <= fc_n;
        op_q     <= op_i;
        total_q  <= fc_total;
        sp_adj_q <= fc_sp_adj;
      end else if ((state_q == PP_MEM) && step_ok && (j_q != n_q)) begin
        j_q <= j_q + 4'd1;
      end else if (state_d == PP_IDLE) begin
        j_q <= '0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    mem_reg_o = '0;
    mem_off_o = '0;
    alu_we_o  = 1'b0;
    alu_rd_o  = '0;
    alu_imm_o = '0;
    ret_o     = 1'b0;
    done_o    = 1'b0;
    unique case (state_q)
      PP_IDLE: if (accept && !fc_illegal) state_d = PP_MEM;
      PP_MEM: begin
        // Step j moves slot N-j, so the highest-numbered register goes first.
        mem_req_o = 1'b1;
        mem_we_o  = (op_q == PP_PUSH);
        mem_reg_o = pp_reg_of(n_q - j_q);
        mem_off_o = (op_q == PP_PUSH) ? -j_bytes : (total_q - j_bytes);
        if (step_ok && (j_q == n_q)) state_d = PP_SPADJ;
      end
      PP_SPADJ: begin
        alu_we_o  = 1'b1;
        alu_rd_o  = PP_REG_SP;
        alu_imm_o = sp_adj_q;
        done_o    = (op_q == PP_PUSH) || (op_q == PP_POP);
        if (!stall_i) begin
          if (op_q == PP_POPRETZ)     state_d = PP_ZERO;
          else if (op_q == PP_POPRET) state_d = PP_RET;
          else                        state_d = PP_IDLE;
        end
      end
      PP_ZERO: begin
        alu_we_o = 1'b1;
        alu_rd_o = PP_REG_A0;
        if (!stall_i) state_d = PP_RET;
      end
      PP_RET: begin
        ret_o  = 1'b1;
        done_o = 1'b1;
        if (!stall_i) state_d = PP_IDLE;
      end
      default: state_d = PP_IDLE;
    endcase
    // A flush wins over stall and grant and silences every strobe at once.
    if (kill_i && (state_q != PP_IDLE)) begin
      state_d   = PP_IDLE;
      mem_req_o = 1'b0;
      mem_we_o  = 1'b0;
      mem_reg_o = '0;
      mem_off_o = '0;
      alu_we_o  = 1'b0;
      alu_rd_o  = '0;
      alu_imm_o = '0;
      ret_o     = 1'b0;
      done_o    = 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_pushpop_sequencer.sv
// Bench for riscv_pushpop_sequencer: 32- and 64-bit instances share stimulus;
// a step-list model is checked every cycle, plus hand-computed literals.
module tb_riscv_pushpop_sequencer;
  import riscv_defines::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, stall = 1'b0, kill = 1'b0, gnt = 1'b1;
  logic [1:0] op = 2'd0;
  logic [3:0] rlist = 4'd0;
  logic [4:0] spimm = 5'd0;

  logic        req_a[2], we_a[2], aluwe_a[2], ret_a[2], busy_a[2], done_a[2], ill_a[2];
  logic [4:0]  mreg_a[2], rd_a[2];
  logic [2:0]  dbg_a[2];
  logic [63:0] off_a[2], imm_a[2];
  logic [31:0] off32, imm32;
  logic [63:0] off64, imm64;

  assign off_a[0] = {32'h0, off32};
  assign imm_a[0] = {32'h0, imm32};
  assign off_a[1] = off64;
  assign imm_a[1] = imm64;

  riscv_pushpop_sequencer #(.XLEN(32), .STACK_ALIGN(16), .SPIMM_W(5)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op), .rlist_i(rlist),
    .spimm_i(spimm), .stall_i(stall), .kill_i(kill), .mem_gnt_i(gnt),
    .mem_req_o(req_a[0]), .mem_we_o(we_a[0]), .mem_reg_o(mreg_a[0]), .mem_off_o(off32),
    .alu_we_o(aluwe_a[0]), .alu_rd_o(rd_a[0]), .alu_imm_o(imm32), .ret_o(ret_a[0]),
    .busy_o(busy_a[0]), .done_o(done_a[0]), .illegal_o(ill_a[0]), .dbg_state_o(dbg_a[0])
  );

  riscv_pushpop_sequencer #(.XLEN(64), .STACK_ALIGN(16), .SPIMM_W(5)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op), .rlist_i(rlist),
    .spimm_i(spimm), .stall_i(stall), .kill_i(kill), .mem_gnt_i(gnt),
    .mem_req_o(req_a[1]), .mem_we_o(we_a[1]), .mem_reg_o(mreg_a[1]), .mem_off_o(off64),
    .alu_we_o(aluwe_a[1]), .alu_rd_o(rd_a[1]), .alu_imm_o(imm64), .ret_o(ret_a[1]),
    .busy_o(busy_a[1]), .done_o(done_a[1]), .illegal_o(ill_a[1]), .dbg_state_o(dbg_a[1])
  );

  // model: per instance, the list of output steps the sequence still owes
  typedef struct packed {
    logic        is_mem;
    logic        we;
    logic [4:0]  mreg;
    logic [63:0] off;
    logic        alu_we;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic        ret;
    logic        done;
  } step_t;

  step_t       mq[2][$];
  logic        ill_exp[2];
  logic [68:0] log_mem[2][$];
  logic [68:0] log_alu[2][$];
  int          ret_cnt[2], ill_cnt[2], done_cyc[2];
  int          cyc = 0, start_cyc = 0;
  int          checks = 0, errors = 0;
  int          regs[13] = '{1, 8, 9, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic build(input int i, input int o, input int rl, input int sp);
    step_t  st;
    int     s, n;
    longint m, total;
    s     = (i == 0) ? 4 : 8;
    m     = (i == 0) ? 64'h0000_0000_FFFF_FFFF : -64'sd1;
    n     = (rl == 15) ? 13 : rl - 3;
    total = longint'(((n * s + 15) / 16) * 16 + sp * 16);
    for (int j = 1; j <= n; j++) begin
      st        = '0;
      st.is_mem = 1'b1;
      st.we     = (o == 0);
      st.mreg   = 5'(regs[n - j]);
      st.off    = ((o == 0) ? -longint'(j * s) : total - longint'(j * s)) & m;
      mq[i].push_back(st);
    end
    st        = '0;
    st.alu_we = 1'b1;
    st.rd     = 5'd2;
    st.imm    = ((o == 0) ? -total : total) & m;
    st.done   = (o < 2);
    mq[i].push_back(st);
    if (o == 3) begin
      st        = '0;
      st.alu_we = 1'b1;
      st.rd     = 5'd10;
      mq[i].push_back(st);
    end
    if (o >= 2) begin
      st      = '0;
      st.ret  = 1'b1;
      st.done = 1'b1;
      mq[i].push_back(st);
    end
  endtask

  task automatic model_step();
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mq[i].delete();
        ill_exp[i] = 1'b0;
      end else if (mq[i].size() > 0) begin
        ill_exp[i] = 1'b0;
        if (kill) mq[i].delete();
        else if (!stall && (!mq[i][0].is_mem || gnt)) void'(mq[i].pop_front());
      end else begin
        ill_exp[i] = start && !stall && (rlist < 4'd4);
        if (start && !stall && (rlist >= 4'd4)) build(i, int'(op), int'(rlist), int'(spimm));
      end
    end
  endtask

  task automatic compare_cycle();
    for (int i = 0; i < 2; i++) begin
      step_t e;
      logic  b;
      string p;
      p = (i == 0) ? "x32" : "x64";
      e = '0;
      if (mq[i].size() > 0 && !kill) e = mq[i][0];
      b = (mq[i].size() > 0) || (rst_n && start && !stall && (rlist >= 4'd4));
      chk({p, "_req"},   64'(req_a[i]),   64'(e.is_mem));
      chk({p, "_we"},    64'(we_a[i]),    64'(e.we));
      chk({p, "_reg"},   64'(mreg_a[i]),  64'(e.mreg));
      chk({p, "_off"},   off_a[i],        e.off);
      chk({p, "_alu_we"}, 64'(aluwe_a[i]), 64'(e.alu_we));
      chk({p, "_rd"},    64'(rd_a[i]),    64'(e.rd));
      chk({p, "_imm"},   imm_a[i],        e.imm);
      chk({p, "_ret"},   64'(ret_a[i]),   64'(e.ret));
      chk({p, "_done"},  64'(done_a[i]),  64'(e.done));
      chk({p, "_busy"},  64'(busy_a[i]),  64'(b));
      chk({p, "_ill"},   64'(ill_a[i]),   64'(ill_exp[i]));
      chk({p, "_idle"},  64'(dbg_a[i] == PP_IDLE), 64'(mq[i].size() == 0));
      if (req_a[i] && gnt && !stall && !kill) log_mem[i].push_back({mreg_a[i], off_a[i]});
      if (aluwe_a[i] && !stall && !kill) log_alu[i].push_back({rd_a[i], imm_a[i]});
      if (done_a[i] && !stall && !kill) done_cyc[i] = cyc;
      if (ret_a[i] && !stall && !kill) ret_cnt[i]++;
      if (ill_a[i]) ill_cnt[i]++;
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 2; i++) begin
      log_mem[i].delete();
      log_alu[i].delete();
      ret_cnt[i]  = 0;
      ill_cnt[i]  = 0;
      done_cyc[i] = -1;
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [3:0] rl, input logic [4:0] sp);
    op        = o;
    rlist     = rl;
    spimm     = sp;
    start     = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy_a[0] || busy_a[1]) && n < 100);
    chk("idle_timeout", 64'(busy_a[0] | busy_a[1]), 64'd0);
    step();
  endtask

  initial begin
    clear_logs();
    ill_exp[0] = 1'b0;
    ill_exp[1] = 1'b0;
    fork
      forever begin @(posedge clk); model_step(); end
      forever begin @(negedge clk); compare_cycle(); end
    join_none
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req",  64'(req_a[0]),  64'd0);
    chk("rst_busy", 64'(busy_a[0]), 64'd0);
    chk("rst_off",  off_a[1],       64'd0);
    step();

    // PUSH rlist=5 spimm=1, 32-bit: s0@-4, ra@-8, sp -= 32, 4-cycle latency
    clear_logs();
    issue(2'd0, 4'd5, 5'd1);
    wait_idle();
    chk("push5_cnt",  64'(log_mem[0].size()), 64'd2);
    chk("push5_r0",   64'(log_mem[0][0]), {5'd8, 64'h0000_0000_FFFF_FFFC});
    chk("push5_r1",   64'(log_mem[0][1]), {5'd1, 64'h0000_0000_FFFF_FFF8});
    chk("push5_sp",   64'(log_alu[0][0]), {5'd2, 64'h0000_0000_FFFF_FFE0});
    chk("push5_lat",  64'(done_cyc[0] - start_cyc + 1), 64'd4);

    // POP rlist=15, 32-bit: s11@60 ... ra@12, sp += 64
    clear_logs();
    issue(2'd1, 4'd15, 5'd0);
    wait_idle();
    chk("pop15_cnt",  64'(log_mem[0].size()), 64'd13);
    chk("pop15_r0",   64'(log_mem[0][0]), {5'd27, 64'd60});
    chk("pop15_r1",   64'(log_mem[0][1]), {5'd26, 64'd56});
    chk("pop15_last", 64'(log_mem[0][12]), {5'd1, 64'd12});
    chk("pop15_sp",   64'(log_alu[0][0]), {5'd2, 64'd64});

    // POPRETZ rlist=4, 64-bit: ra@8, sp += 16, a0 = 0, ret with done
    clear_logs();
    issue(2'd3, 4'd4, 5'd0);
    wait_idle();
    chk("prz_ld",   64'(log_mem[1][0]), {5'd1, 64'd8});
    chk("prz_sp",   64'(log_alu[1][0]), {5'd2, 64'd16});
    chk("prz_a0",   64'(log_alu[1][1]), {5'd10, 64'd0});
    chk("prz_ret",  64'(ret_cnt[1]), 64'd1);
    chk("prz_lat",  64'(done_cyc[1] - start_cyc + 1), 64'd5);

    // PUSH rlist=6 with the first store held off for 3 cycles
    clear_logs();
    gnt = 1'b0;
    issue(2'd0, 4'd6, 5'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_req", 64'(req_a[0]), 64'd1);
      chk("hold_reg", 64'(mreg_a[0]), 64'd9);
      chk("hold_off", off_a[0], 64'h0000_0000_FFFF_FFFC);
      step();
    end
    gnt = 1'b1;
    wait_idle();
    chk("hold_lat", 64'(done_cyc[0] - start_cyc + 1), 64'd8);

    // POP rlist=10 killed at j=3, then a new PUSH accepted immediately
    clear_logs();
    issue(2'd1, 4'd10, 5'd0);
    step();
    step();
    kill = 1'b1;
    @(negedge clk);
    chk("kill_req", 64'(req_a[0]), 64'd0);
    step();
    kill = 1'b0;
    chk("kill_loads", 64'(log_mem[0].size()), 64'd2);
    chk("kill_noalu", 64'(log_alu[0].size()), 64'd0);
    chk("kill_noret", 64'(ret_cnt[0]), 64'd0);
    clear_logs();
    issue(2'd0, 4'd4, 5'd0);
    wait_idle();
    chk("after_kill_st", 64'(log_mem[0][0]), {5'd1, 64'h0000_0000_FFFF_FFFC});
    chk("after_kill_sp", 64'(log_alu[0][0]), {5'd2, 64'h0000_0000_FFFF_FFF0});

    // illegal rlist=2
    clear_logs();
    issue(2'd0, 4'd2, 5'd0);
    repeat (4) step();
    chk("ill_pulse", 64'(ill_cnt[0]), 64'd1);
    chk("ill_noreq", 64'(log_mem[0].size()), 64'd0);

    // PUSH rlist=5 stalled 2 cycles mid-sequence
    clear_logs();
    issue(2'd0, 4'd5, 5'd0);
    stall = 1'b1;
    step();
    step();
    stall = 1'b0;
    wait_idle();
    chk("stall_lat", 64'(done_cyc[0] - start_cyc + 1), 64'd6);
    chk("stall_cnt", 64'(log_mem[0].size()), 64'd2);

    // POPRET rlist=7, spimm=2, 64-bit: 4 loads, sp += 32+32, ret, no a0 clear
    clear_logs();
    issue(2'd2, 4'd7, 5'd2);
    wait_idle();
    chk("pr_first", 64'(log_mem[1][0]), {5'd18, 64'd56});
    chk("pr_sp",    64'(log_alu[1][0]), {5'd2, 64'd64});
    chk("pr_alu_n", 64'(log_alu[1].size()), 64'd1);
    chk("pr_ret",   64'(ret_cnt[1]), 64'd1);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
